// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: sequential AXI read master with up to DEPTH requests
// in flight or buffered, in-order prefetch ring buffer and redirect flush/drain.
module ifu_prefetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              f_valid_o,
  input  logic              D_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o,
  output logic              fault_o,
  output logic              mst_ar_valid_o,
  output logic [ADDR_W-1:0] mst_ar_addr_o,
  input  logic              mst_ar_ready_i,
  input  logic              mst_r_valid_i,
  input  logic [31:0]       mst_r_data_i,
  input  logic [1:0]        mst_r_resp_i,
  output logic              mst_r_ready_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     alloc_ptr, fill_ptr, head_ptr, drop_cnt;
  logic [ADDR_W-1:0] fetch_pc, ar_addr_q;
  logic              ar_valid_q;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [31:0]       inst_mem  [DEPTH];
  logic              fault_mem [DEPTH];

  logic [PW-1:0] occupancy;
  logic          launch, ar_hs, r_hs, r_fill, pop;

  // Credit is taken from registered pointers only; a pop this cycle frees a slot next cycle.
  assign occupancy = alloc_ptr - head_ptr;
  assign launch    = !redirect_i && (drop_cnt == '0) && (!ar_valid_q || mst_ar_ready_i)
                     && (occupancy < PW'(DEPTH));
  assign ar_hs     = ar_valid_q && mst_ar_ready_i;
  assign r_hs      = mst_r_valid_i && mst_r_ready_o;
  assign r_fill    = r_hs && (drop_cnt == '0) && !redirect_i;
  assign pop       = f_valid_o && D_ready_i;

  assign mst_ar_valid_o = ar_valid_q;
  assign mst_ar_addr_o  = ar_addr_q;
  assign mst_r_ready_o  = (drop_cnt != '0) || (alloc_ptr != fill_ptr);

  assign f_valid_o = (head_ptr != fill_ptr) && !redirect_i;
  assign pc_o      = f_valid_o ? pc_mem[head_ptr[IW-1:0]]    : '0;
  assign inst_o    = f_valid_o ? inst_mem[head_ptr[IW-1:0]]  : '0;
  assign fault_o   = f_valid_o ? fault_mem[head_ptr[IW-1:0]] : 1'b0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      drop_cnt   <= '0;
      fetch_pc   <= RESET_PC;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
    end else if (redirect_i) begin
      // Every allocated-but-unfilled request, including a still-pending AR, will
      // return a beat that must be thrown away; a beat taken this cycle is already gone.
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      fetch_pc  <= redirect_pc_i;
      drop_cnt  <= drop_cnt + (alloc_ptr - fill_ptr) - PW'(r_hs);
      if (ar_hs) ar_valid_q <= 1'b0;
    end else begin
      if (launch) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= fetch_pc;
        alloc_ptr  <= alloc_ptr + PW'(1);
        fetch_pc   <= fetch_pc + ADDR_W'(4);
      end else if (ar_hs) begin
        ar_valid_q <= 1'b0;
      end
      if (r_hs) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - PW'(1);
        else                fill_ptr <= fill_ptr + PW'(1);
      end
      if (pop) head_ptr <= head_ptr + PW'(1);
    end
  end

  // NOTE: the buffer storage has no reset; pointers alone define which slots are
  // valid and outputs are forced to 0 when the head is empty.
  always_ff @(posedge clk_i) begin
    if (launch) pc_mem[alloc_ptr[IW-1:0]] <= fetch_pc;
    if (r_fill) begin
      inst_mem[fill_ptr[IW-1:0]]  <= mst_r_data_i;
      fault_mem[fill_ptr[IW-1:0]] <= (mst_r_resp_i != 2'b00);
    end
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with a multi-outstanding AXI read master and an in-order prefetch buffer. It replaces the single-request fetch front end. It sequentially fetches instructions from a fetch PC, keeps up to DEPTH requests in flight or buffered, and hands {pc, inst, fault} to the IF/ID stage over a valid/ready handshake. A redirect from the back end flushes the buffer and silently drains stale responses.

## Interface
- ADDR_W, 32: address and PC width.
- DEPTH, 4: buffer entries and maximum outstanding requests; power of 2, ≥2.
- RESET_PC, 32'h8000_0000: fetch PC after reset.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  ADDR_W  new fetch PC; must be 4-byte aligned.
- f_valid_o  out  1  head entry valid toward decode.
- D_ready_i  in  1  decode accepts the head entry.
- pc_o  out  ADDR_W  PC of the head entry.
- inst_o  out  32  instruction word of the head entry.
- fault_o  out  1  head entry came back with rresp ≠ 0.
- mst_ar_valid_o  out  1  AXI AR valid.
- mst_ar_addr_o  out  ADDR_W  AXI AR address.
- mst_ar_ready_i  in  1  AXI AR ready.
- mst_r_valid_i  in  1  AXI R valid.
- mst_r_data_i  in  32  AXI R data.
- mst_r_resp_i  in  2  AXI R response.
- mst_r_ready_o  out  1  AXI R ready.

## Operation
- Ring buffer of DEPTH entries {pc, inst, fault}, with three pointers of $clog2(DEPTH)+1 bits: alloc, fill and head. All pointers wrap modulo 2·DEPTH. Occupancy is alloc−head.
- Registers: fetch_pc (init RESET_PC), ar_valid_q, ar_addr_q, drop_cnt ($clog2(DEPTH)+1 bits).
- Launch condition: !redirect_i && drop_cnt==0 && (!ar_valid_q || mst_ar_ready_i) && (alloc−head) < DEPTH. Registered values only; a same-cycle pop does not add credit.
- On launch:
  - ar_valid_q←1 and ar_addr_q←fetch_pc.
  - The slot at alloc gets pc=fetch_pc, then alloc++.
  - fetch_pc += 4 (wraps modulo 2^ADDR_W).
- An AR handshake without a launch clears ar_valid_q. Once raised, mst_ar_valid_o never drops before its handshake (AXI rule), including across redirect.
- mst_r_ready_o = (drop_cnt≠0) || (alloc≠fill).
- R handshake while drop_cnt≠0: the response is discarded and drop_cnt decrements.
- R handshake while drop_cnt==0: the slot at fill gets inst=rdata and fault=(rresp≠0), then fill++. Responses are in order; ID is not used.
- f_valid_o = (head≠fill) && !redirect_i. When f_valid_o=0, pc_o, inst_o and fault_o are driven 0.
- Pop: f_valid_o && D_ready_i causes head++.
- Redirect in cycle t:
  - alloc, fill and head are all set to 0.
  - fetch_pc←redirect_pc_i.
  - drop_cnt←drop_cnt + (alloc−fill) − (R handshake in t ? 1 : 0).
  - Any pending un-handshaked AR is counted in drop_cnt. It stays asserted with its old address and its response is dropped.
  - No launch and no pop occur in cycle t. An R handshake in cycle t is discarded.
- Launch stays blocked until drop_cnt returns to 0.

## Timing
- Reset (rst_i=0): immediately f_valid_o=0, mst_ar_valid_o=0, mst_ar_addr_o=0, mst_r_ready_o=0, pc_o=inst_o=fault_o=0. All pointers and drop_cnt are 0, fetch_pc=RESET_PC.
- First AR: mst_ar_valid_o rises after the first rising edge with rst_i=1.
- Throughput: one AR per cycle while ar_ready=1 and credit is available. One pop per cycle.
- Latency: an R handshake at edge t gives f_valid_o high in cycle t+1 (registered buffer, no bypass).
- Full: with DEPTH entries allocated, AR issue stops. A pop at edge t allows a launch in cycle t+1.
- Redirect to first new AR: at least 1 cycle with no stale traffic. Otherwise the delay is drop_cnt R beats plus 1 cycle.
- Back-to-back redirects: each one re-accumulates drop_cnt. drop_cnt never exceeds DEPTH.

## Test plan
- Cold fetch: RESET_PC=0x8000_0000; slave always ready with rdata=0x0010_0073 and rresp=0; D_ready=1. Required: AR addresses 0x8000_0000, _0004, _0008, … one per cycle. Outputs appear in order with pc matching the address and inst=0x0010_0073.
- Backpressure: DEPTH=4, D_ready=0. Required: exactly 4 ARs (0x8000_0000–0x8000_000C), then ar_valid stays 0. After D_ready=1, one pop per cycle and AR 0x8000_0010 follows.
- Held AR across redirect: ar_ready=0 with AR 0x8000_0000 pending; pulse redirect to 0x8000_1000. Required: ar_valid stays 1 with addr 0x8000_0000. Its response is dropped. The next AR is 0x8000_1000 and the first output is pc 0x8000_1000.
- Redirect with 3 responses outstanding, one R beat in the redirect cycle. Required: drop_cnt=2. Two more beats are absorbed with r_ready=1, and no old-PC entry ever reaches decode.
- Fault: rresp=2'b10 on the second beat. Required: pc 0x8000_0004 is output with fault_o=1. Neighbouring entries have fault_o=0.
- Mid-operation reset: assert rst_i=0 with 2 in flight. Required: all outputs go to 0 asynchronously. After release, fetch restarts at 0x8000_0000.
